// File: rtl/lj_frame_fifo_if.sv
// Handshake bundle between the capture sequencer/FIFO, the left-justified
// receiver and the downstream consumer; master is the lj_frame_fifo side.
interface lj_frame_fifo_if #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH_LOG2 = 3
);
    logic                  enable;
    logic                  start;
    logic                  data_ready;
    logic [DATA_WIDTH-1:0] left_in;
    logic [DATA_WIDTH-1:0] right_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_left;
    logic [DATA_WIDTH-1:0] out_right;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic                  timeout;
    logic [15:0]           drop_count;

    modport master (
        input  enable, data_ready, left_in, right_in, out_ready,
        output start, out_valid, out_left, out_right, level,
        overflow, timeout, drop_count
    );

    modport slave (
        output enable, data_ready, left_in, right_in, out_ready,
        input  start, out_valid, out_left, out_right, level,
        overflow, timeout, drop_count
    );
endinterface

// File: rtl/lj_frame_fifo.sv
// Capture sequencer for the left-justified ADC receiver feeding a small
// first-word-fall-through FIFO of stereo frames drained by valid/ready.
module lj_frame_fifo #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 2 * DATA_WIDTH + 8
) (
    input  logic            BCLK,
    input  logic            reset,
    lj_frame_fifo_if.master bus
);
    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam int                  CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]    CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [DEPTH_LOG2:0] LVL_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_PUSH
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [CNT_W-1:0]        r_wait_cnt;
    logic [CNT_W-1:0]        w_wait_cnt_inc;
    logic                    r_dr_prev;
    logic                    w_dr_rise;
    logic [2*DATA_WIDTH-1:0] r_frame;
    logic [2*DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_level;
    logic                    r_overflow;
    logic                    r_timeout;
    logic [15:0]             r_drop_count;
    logic                    w_start;
    logic                    w_capture;
    logic                    w_timeout_hit;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_valid;
    logic                    w_wr_en;
    logic                    w_drop;
    logic [2*DATA_WIDTH-1:0] w_head;

    assign w_wait_cnt_inc = r_wait_cnt + CNT_W'(1);
    assign w_dr_rise      = bus.data_ready & ~r_dr_prev;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state  = r_state;
        w_start       = 1'b0;
        w_capture     = 1'b0;
        w_timeout_hit = 1'b0;
        w_push        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.enable) w_next_state = S_START;
            end
            S_START: begin
                w_start      = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                // A completed frame wins over a timeout landing in the same cycle.
                if (w_dr_rise) begin
                    w_capture    = 1'b1;
                    w_next_state = S_PUSH;
                end else if (w_wait_cnt_inc == CNT_LIMIT) begin
                    w_timeout_hit = 1'b1;
                    w_next_state  = bus.enable ? S_START : S_IDLE;
                end
            end
            S_PUSH: begin
                w_push       = 1'b1;
                w_next_state = bus.enable ? S_START : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge BCLK) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Edge register resets high so a level still asserted after reset is not seen as a new frame.
    always_ff @(posedge BCLK) begin
        if (reset) begin
            r_dr_prev  <= 1'b1;
            r_wait_cnt <= '0;
            r_frame    <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_dr_prev <= bus.data_ready;
            if (w_start) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= w_wait_cnt_inc;
            end
            if (w_capture)     r_frame   <= {bus.left_in, bus.right_in};
            if (w_timeout_hit) r_timeout <= 1'b1;
        end
    end

    assign w_valid = (r_level != '0);
    assign w_full  = (r_level == LVL_FULL);
    assign w_pop   = w_valid & bus.out_ready;
    assign w_wr_en = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge BCLK) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_level <= r_level + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_level <= r_level - (DEPTH_LOG2 + 1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    // NOTE: storage is not reset; the empty-gated head below keeps its contents invisible until written.
    always_ff @(posedge BCLK) begin
        if (!reset && w_wr_en) r_mem[r_wr_ptr] <= r_frame;
    end

    assign w_head = w_valid ? r_mem[r_rd_ptr] : '0;

    assign bus.start      = w_start;
    assign bus.out_valid  = w_valid;
    assign bus.out_left   = w_head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign bus.out_right  = w_head[DATA_WIDTH-1:0];
    assign bus.level      = r_level;
    assign bus.overflow   = r_overflow;
    assign bus.timeout    = r_timeout;
    assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_lj_frame_fifo.sv
// Directed bench for lj_frame_fifo: a behavioural receiver answers each start
// pulse 48 cycles later (or never, when muted); expected values are hand-derived.
module tb_lj_frame_fifo;
    localparam int DW = 24;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc       = 0;
    int   start_cnt = 0;
    int   rx_seq    = 0;
    bit   rx_mute   = 1'b0;
    bit   rx_fixed  = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    int s;
    int t;
    int seq0;
    int sc;

    lj_frame_fifo_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(3)) bus ();

    lj_frame_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(3), .TIMEOUT(2 * DW + 8)) dut (
        .BCLK  (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: clears data_ready on start, presents a new frame 48 cycles later.
    initial begin
        int rx_cnt;
        bit rx_busy;
        rx_cnt  = 0;
        rx_busy = 1'b0;
        bus.data_ready = 1'b0;
        bus.left_in    = '0;
        bus.right_in   = '0;
        forever begin
            @(negedge clk);
            if (bus.start === 1'b1) begin
                start_cnt++;
                bus.data_ready = 1'b0;
                rx_cnt  = 48;
                rx_busy = 1'b1;
            end else if (rx_busy) begin
                rx_cnt--;
                if (rx_cnt == 0) begin
                    rx_busy = 1'b0;
                    if (!rx_mute) begin
                        rx_seq++;
                        bus.left_in    = rx_fixed ? 24'h123456 : DW'(32'h100000 + rx_seq);
                        bus.right_in   = rx_fixed ? 24'hABCDEF : DW'(32'h200000 + rx_seq);
                        bus.data_ready = 1'b1;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [63:0] exp_l(input int k);
        return 64'(DW'(32'h100000 + k));
    endfunction

    function automatic logic [63:0] exp_r(input int k);
        return 64'(DW'(32'h200000 + k));
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rise(input int target, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (rx_seq >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_start(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic do_reset();
        bus.enable    = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        step();
        step();
        reset    = 1'b0;
        rx_fixed = 1'b0;
        rx_mute  = 1'b0;
    endtask

    task automatic drain(input int first, input int count, input string tag);
        bus.out_ready = 1'b1;
        for (int i = 0; i < count; i++) begin
            check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, "_left"},  64'(bus.out_left),  exp_l(first + i));
            check({tag, "_right"}, 64'(bus.out_right), exp_r(first + i));
            step();
        end
        bus.out_ready = 1'b0;
        check({tag, "_empty"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_level0"}, 64'(bus.level), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable    = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        step();
        step();
        check("rst_start",     64'(bus.start),      64'd0);
        check("rst_valid",     64'(bus.out_valid),  64'd0);
        check("rst_level",     64'(bus.level),      64'd0);
        check("rst_overflow",  64'(bus.overflow),   64'd0);
        check("rst_timeout",   64'(bus.timeout),    64'd0);
        check("rst_drop",      64'(bus.drop_count), 64'd0);
        check("rst_out_left",  64'(bus.out_left),   64'd0);
        check("rst_out_right", 64'(bus.out_right),  64'd0);
        reset = 1'b0;

        // Basic capture: out_valid two cycles after the edge, next start at the same time.
        rx_fixed   = 1'b1;
        bus.enable = 1'b1;
        wait_start("t1_first_start");
        s    = cyc;
        seq0 = rx_seq;
        wait_rise(seq0 + 1, "t1_rise");
        check("t1_valid_edge", 64'(bus.out_valid), 64'd0);
        step();
        check("t1_valid_push", 64'(bus.out_valid), 64'd0);
        step();
        check("t1_valid",      64'(bus.out_valid), 64'd1);
        check("t1_level",      64'(bus.level),     64'd1);
        check("t1_left",       64'(bus.out_left),  64'h123456);
        check("t1_right",      64'(bus.out_right), 64'hABCDEF);
        check("t1_next_start", 64'(bus.start),     64'd1);
        check("t1_start_gap",  64'(cyc - s),       64'd50);
        bus.enable = 1'b0;

        // Fill and overflow: ten frames, no reads.
        do_reset();
        seq0       = rx_seq;
        bus.enable = 1'b1;
        wait_rise(seq0 + 10, "t2_rise10");
        bus.enable = 1'b0;
        step();
        step();
        check("t2_level",    64'(bus.level),      64'd8);
        check("t2_overflow", 64'(bus.overflow),   64'd1);
        check("t2_drop",     64'(bus.drop_count), 64'd2);
        check("t2_timeout",  64'(bus.timeout),    64'd0);
        drain(seq0 + 1, 8, "t2_drain");

        // Full FIFO with a pop in the PUSH cycle: no drop, oldest frame leaves.
        do_reset();
        seq0       = rx_seq;
        bus.enable = 1'b1;
        wait_rise(seq0 + 9, "t3_rise9");
        bus.enable = 1'b0;
        check("t3_full", 64'(bus.level), 64'd8);
        step();
        bus.out_ready = 1'b1;
        check("t3_pop_oldest", 64'(bus.out_left), exp_l(seq0 + 1));
        step();
        bus.out_ready = 1'b0;
        check("t3_level",    64'(bus.level),      64'd8);
        check("t3_drop",     64'(bus.drop_count), 64'd0);
        check("t3_overflow", 64'(bus.overflow),   64'd0);
        drain(seq0 + 2, 8, "t3_drain");

        // Disable mid-frame: the frame completes, then no further start.
        do_reset();
        seq0       = rx_seq;
        bus.enable = 1'b1;
        wait_start("t5_start");
        repeat (10) step();
        bus.enable = 1'b0;
        sc = start_cnt;
        wait_rise(seq0 + 1, "t5_rise");
        step();
        step();
        check("t5_valid", 64'(bus.out_valid), 64'd1);
        check("t5_level", 64'(bus.level),     64'd1);
        check("t5_left",  64'(bus.out_left),  exp_l(seq0 + 1));
        repeat (100) step();
        check("t5_no_start", 64'(start_cnt - sc), 64'd0);
        check("t5_level_hold", 64'(bus.level), 64'd1);

        // Timeout: 56 WAIT cycles, flag and new start in the following cycle.
        do_reset();
        rx_mute    = 1'b1;
        bus.enable = 1'b1;
        wait_start("t4_start");
        s = cyc;
        t = -1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.timeout === 1'b1) begin
                t = cyc;
                break;
            end
        end
        check("t4_timeout_cycle", 64'(t - s),         64'd57);
        check("t4_restart",       64'(bus.start),     64'd1);
        check("t4_no_push",       64'(bus.out_valid), 64'd0);

        // Reset mid-operation with level 5, sticky timeout set, FSM waiting.
        rx_mute = 1'b0;
        seq0    = rx_seq;
        wait_rise(seq0 + 5, "t6_rise5");
        step();
        step();
        step();
        check("t6_level5",      64'(bus.level),   64'd5);
        check("t6_timeout_set", 64'(bus.timeout), 64'd1);
        wait_rise(seq0 + 6, "t6_rise6");
        reset      = 1'b1;
        bus.enable = 1'b0;
        step();
        reset = 1'b0;
        check("t6_level",     64'(bus.level),      64'd0);
        check("t6_valid",     64'(bus.out_valid),  64'd0);
        check("t6_timeout",   64'(bus.timeout),    64'd0);
        check("t6_overflow",  64'(bus.overflow),   64'd0);
        check("t6_drop",      64'(bus.drop_count), 64'd0);
        check("t6_start",     64'(bus.start),      64'd0);
        check("t6_out_left",  64'(bus.out_left),   64'd0);
        sc = start_cnt;
        repeat (60) step();
        check("t6_idle_no_start", 64'(start_cnt - sc), 64'd0);
        check("t6_stale_ignored", 64'(bus.level),      64'd0);
        bus.enable = 1'b1;
        wait_rise(seq0 + 7, "t6_rise7");
        step();
        step();
        check("t6_new_level", 64'(bus.level),    64'd1);
        check("t6_new_left",  64'(bus.out_left), exp_l(seq0 + 7));
        bus.enable = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
